rpn_ctrl: RTL and testbench
===========================

RPN_CTRL -- requirements
Module: rpn_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports TOK_STB in 1 token valid; TOK_DAT in 32 token value; TOK_IS_OP in 1 (1 = operator ASCII in TOK_DAT[7:0]).
REQ-004 SHALL have port TOK_ACK  out  1  one-cycle token-accepted pulse.
REQ-005 SHALL have ports STK_PUSH_STB out 1; STK_PUSH_DAT out 32; STK_PUSH_ACK in 1 (stack push handshake).
REQ-006 SHALL have ports STK_POP_STB in 1 (stack non-empty); STK_POP_DAT in 32 (top of stack, combinational); STK_POP_ACK out 1 (pop pulse).
REQ-007 SHALL have ports CLR in 1 (synchronous clear request); RES_DAT out 32; RES_VLD out 1; ERR out 1; BUSY out 1.

Function
REQ-008 SHALL implement FSM states IDLE, PUSH, POP_B, POP_A, EXEC, PUSH_R, DRAIN.
REQ-009 SHALL hold 5-bit DEPTH counter, range 0..16: +1 on each completed push, -1 on each pop.
REQ-010 SHALL assert TOK_ACK for one cycle only in IDLE with TOK_STB=1, ERR=0, CLR=0.
REQ-011 Accepted operand (TOK_IS_OP=0): DEPTH<16 -> PUSH with STK_PUSH_DAT=TOK_DAT; DEPTH=16 -> set ERR, stay IDLE, no push.
REQ-012 In PUSH/PUSH_R SHALL hold STK_PUSH_STB=1 and STK_PUSH_DAT stable until STK_PUSH_ACK=1 sampled, then go IDLE, DEPTH+1.
REQ-013 Accepted operator: DEPTH<2 or unsupported code -> set ERR, stay IDLE, no stack access; else -> POP_B.
REQ-014 POP_B: wait for STK_POP_STB=1, then capture STK_POP_DAT as B and pulse STK_POP_ACK the same cycle, DEPTH-1, -> POP_A.
REQ-015 POP_A: same rule, capturing A, -> EXEC.
REQ-016 EXEC (exactly one cycle): R = A op B; '+' A+B, '-' A-B, '*' low 32 bits of A*B; 32-bit two's-complement wrap, no overflow flag; -> PUSH_R with STK_PUSH_DAT=R.
REQ-017 Latency: operand push 2 cycles from TOK_ACK with ACK tied high; operator push of result 5 cycles from TOK_ACK with STB/ACK tied high.
REQ-018 STK_PUSH_STB and STK_POP_ACK SHALL never be high in the same cycle.
REQ-019 RES_DAT SHALL update to the value pushed on every completed push; RES_VLD = (DEPTH==1) and ERR=0.
REQ-020 ERR SHALL be sticky; BUSY = 1 in any state other than IDLE.
REQ-021 CLR=1 in any state SHALL abort the current operation, clear ERR, and go DRAIN next cycle.
REQ-022 DRAIN: pulse STK_POP_ACK each cycle STK_POP_STB=1; when STK_POP_STB=0, set DEPTH=0, RES_VLD=0, go IDLE.
REQ-023 TOK_STB during BUSY SHALL be ignored (no TOK_ACK) and held by the source.

Reset
REQ-024 RST SHALL force state IDLE, DEPTH=0, A=B=0, RES_DAT=0, STK_PUSH_DAT=0, and all strobes, RES_VLD, ERR, BUSY to 0.
REQ-025 RST mid-operation SHALL abandon it with no further stack strobes; the stack is reset by the same RST.

Configuration
REQ-026 Macro RPN_CTRL_DIV_EN defined: operator '/' supported; R = A/B signed, truncated toward zero; B=0 -> set ERR, no push, DEPTH remains reduced by 2.
REQ-027 Macro RPN_CTRL_DIV_EN undefined: '/' is an unsupported code per REQ-013 and no divider logic is synthesized.

Verification
REQ-028 Tokens 3, 4, '+' with ACK tied high -> stack push of 7, RES_DAT=7, RES_VLD=1, ERR=0.
REQ-029 Tokens 2, 5, '-' -> RES_DAT=32'hFFFFFFFD; tokens 32'h10000, 32'h10000, '*' -> RES_DAT=0.
REQ-030 17 operands -> first 16 pushed, 17th sets ERR with no push; CLR -> 16 pops, DEPTH=0, ERR=0.
REQ-031 Token '+' at DEPTH=1 -> ERR=1, no STK_POP_ACK; a following token gets no TOK_ACK until CLR.
REQ-032 STK_PUSH_ACK withheld 3 cycles in PUSH_R -> STB and DAT held stable; completion on the 4th cycle.
REQ-033 RST asserted during EXEC -> all outputs 0 next edge; with RPN_CTRL_DIV_EN, tokens 7, 0, '/' -> ERR=1.

Source files
------------

// File: rtl/rpn_ctrl.sv
// rpn_ctrl: RPN calculator controller sequencing operand/operator tokens onto an external stack.
// Defining RPN_CTRL_DIV_EN adds the signed '/' operator; without it '/' is rejected as unsupported.
module rpn_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TOK_STB,
  input  logic [31:0] TOK_DAT,
  input  logic        TOK_IS_OP,
  output logic        TOK_ACK,
  output logic        STK_PUSH_STB,
  output logic [31:0] STK_PUSH_DAT,
  input  logic        STK_PUSH_ACK,
  input  logic        STK_POP_STB,
  input  logic [31:0] STK_POP_DAT,
  output logic        STK_POP_ACK,
  input  logic        CLR,
  output logic [31:0] RES_DAT,
  output logic        RES_VLD,
  output logic        ERR,
  output logic        BUSY,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH   = 3'd1,
    POP_B  = 3'd2,
    POP_A  = 3'd3,
    EXEC   = 3'd4,
    PUSH_R = 3'd5,
    DRAIN  = 3'd6
  } state_t;

  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_MUL = 8'h2A;
  localparam logic [7:0] OP_DIV = 8'h2F;
  localparam logic [4:0] DEPTH_MAX = 5'd16;

  state_t      state, state_nxt;
  logic [4:0]  depth;
  logic [31:0] a, b, push_dat, res_dat, alu_res;
  logic [7:0]  op;
  logic        err, op_ok, div_zero;
  logic        tok_take, push_done, pop_take, drain_pop;

  // Handshakes: a transfer happens on a rising edge where the strobe and its ack are both high;
  // strobe sources hold data stable until then. Pops are acked combinationally off STK_POP_STB.
  always_comb begin
    op_ok = (TOK_DAT[7:0] == OP_ADD) || (TOK_DAT[7:0] == OP_SUB) || (TOK_DAT[7:0] == OP_MUL);
`ifdef RPN_CTRL_DIV_EN
    op_ok = op_ok || (TOK_DAT[7:0] == OP_DIV);
`endif
  end

  assign tok_take  = (state == IDLE) && TOK_STB && !err && !CLR;
  assign push_done = ((state == PUSH) || (state == PUSH_R)) && STK_PUSH_ACK && !CLR;
  assign pop_take  = ((state == POP_B) || (state == POP_A)) && STK_POP_STB && !CLR;
  assign drain_pop = (state == DRAIN) && STK_POP_STB;

  always_comb begin
    alu_res  = a + b;
    div_zero = 1'b0;
    case (op)
      OP_SUB: alu_res = a - b;
      OP_MUL: alu_res = a * b;
`ifdef RPN_CTRL_DIV_EN
      OP_DIV: begin
        div_zero = (b == 32'd0);
        alu_res  = div_zero ? 32'd0 : 32'($signed(a) / $signed(b));
      end
`endif
      default: alu_res = a + b;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (CLR) begin
      state_nxt = DRAIN;
    end else begin
      case (state)
        IDLE: if (tok_take) begin
          if (!TOK_IS_OP) state_nxt = (depth < DEPTH_MAX) ? PUSH : IDLE;
          else            state_nxt = (depth >= 5'd2 && op_ok) ? POP_B : IDLE;
        end
        PUSH, PUSH_R: if (STK_PUSH_ACK) state_nxt = IDLE;
        POP_B:  if (STK_POP_STB) state_nxt = POP_A;
        POP_A:  if (STK_POP_STB) state_nxt = EXEC;
        EXEC:   state_nxt = div_zero ? IDLE : PUSH_R;
        DRAIN:  if (!STK_POP_STB) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    TOK_ACK      = tok_take;
    STK_PUSH_STB = (state == PUSH) || (state == PUSH_R);
    STK_POP_ACK  = pop_take || drain_pop;
    BUSY         = (state != IDLE);
    // Depth passes through 1 while draining, so the result is never flagged valid in DRAIN.
    RES_VLD      = (depth == 5'd1) && !err && (state != DRAIN);
  end

  assign STK_PUSH_DAT = push_dat;
  assign RES_DAT      = res_dat;
  assign ERR          = err;
  assign dbg_state    = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      depth    <= 5'd0;
      a        <= 32'd0;
      b        <= 32'd0;
      op       <= 8'd0;
      push_dat <= 32'd0;
      res_dat  <= 32'd0;
      err      <= 1'b0;
    end else begin
      if (CLR) err <= 1'b0;
      case (state)
        IDLE: if (tok_take) begin
          if (!TOK_IS_OP) begin
            if (depth < DEPTH_MAX) push_dat <= TOK_DAT;
            else                   err      <= 1'b1;
          end else if (depth >= 5'd2 && op_ok) begin
            op <= TOK_DAT[7:0];
          end else begin
            err <= 1'b1;
          end
        end
        PUSH, PUSH_R: if (push_done) begin
          depth   <= depth + 5'd1;
          res_dat <= push_dat;
        end
        POP_B: if (pop_take) begin
          b     <= STK_POP_DAT;
          depth <= depth - 5'd1;
        end
        POP_A: if (pop_take) begin
          a     <= STK_POP_DAT;
          depth <= depth - 5'd1;
        end
        EXEC: if (!CLR) begin
          if (div_zero) err      <= 1'b1;
          else          push_dat <= alu_res;
        end
        DRAIN: begin
          if (drain_pop) depth <= (depth != 5'd0) ? depth - 5'd1 : 5'd0;
          else           depth <= 5'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_ctrl.sv
// tb_rpn_ctrl: directed table-driven bench for rpn_ctrl with a behavioural 16-entry stack.
// Define RPN_CTRL_DIV_EN for both files to exercise the divide operator.
module tb_rpn_ctrl;

  logic        clk, rst;
  logic        tok_stb, tok_is_op, tok_ack;
  logic [31:0] tok_dat;
  logic        push_stb, push_ack, pop_stb, pop_ack, clr;
  logic [31:0] push_dat, pop_dat, res_dat;
  logic        res_vld, err, busy;
  logic [2:0]  dbg_state;

  rpn_ctrl dut (
    .CLK(clk), .RST(rst),
    .TOK_STB(tok_stb), .TOK_DAT(tok_dat), .TOK_IS_OP(tok_is_op), .TOK_ACK(tok_ack),
    .STK_PUSH_STB(push_stb), .STK_PUSH_DAT(push_dat), .STK_PUSH_ACK(push_ack),
    .STK_POP_STB(pop_stb), .STK_POP_DAT(pop_dat), .STK_POP_ACK(pop_ack),
    .CLR(clr), .RES_DAT(res_dat), .RES_VLD(res_vld), .ERR(err), .BUSY(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural stack
  logic [31:0] stk_mem [16];
  int sp;
  assign pop_stb = (sp > 0);
  assign pop_dat = (sp > 0) ? stk_mem[4'(sp - 1)] : 32'd0;
  always @(posedge clk or posedge rst) begin
    if (rst) sp <= 0;
    else if (push_stb && push_ack && sp < 16) begin
      stk_mem[4'(sp)] <= push_dat;
      sp <= sp + 1;
    end else if (pop_ack && sp > 0) sp <= sp - 1;
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  int ack_cyc = 0;
  int push_done_cyc = 0;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (push_stb && pop_ack) begin
        n_checks++; n_fail++;
        $display("FAIL push_pop_overlap: push_stb=1 pop_ack=1 at cycle %0d, required not both", cyc);
      end
      if (pop_ack) pop_cnt++;
      if (push_stb && push_ack) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL push_data: unexpected push of %h, required no push", push_dat);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (push_dat !== e) begin
            n_fail++;
            $display("FAIL push_data: got %h required %h", push_dat, e);
          end
        end
        push_done_cyc = cyc + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // drivers
  task automatic send_tok(input logic is_op, input logic [31:0] d, input int max_cyc,
                          output logic acked);
    tok_stb = 1'b1; tok_is_op = is_op; tok_dat = d; acked = 1'b0;
    for (int i = 0; i < max_cyc && !acked; i++) begin
      #1;
      if (tok_ack) begin acked = 1'b1; ack_cyc = cyc; end
      @(negedge clk);
    end
    tok_stb = 1'b0; tok_is_op = 1'b0; tok_dat = 32'd0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (busy && i < 100) begin @(negedge clk); i++; end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: busy=1 after 100 cycles, required 0", tag);
    end
  endtask

  task automatic push_val(input logic [31:0] d, input logic expect_push);
    logic acked;
    if (expect_push) exp_q.push_back(d);
    send_tok(1'b0, d, 5, acked);
    check("operand_ack", {31'd0, acked}, 32'd1);
    wait_idle("operand");
  endtask

  task automatic send_op(input logic [7:0] code);
    logic acked;
    send_tok(1'b1, {24'd0, code}, 5, acked);
    check("operator_ack", {31'd0, acked}, 32'd1);
    wait_idle("operator");
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_idle("clear");
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0;
    logic acked;

    vecs[0] = '{32'd3,          32'd4,          8'h2B, 32'd7};
    vecs[1] = '{32'd2,          32'd5,          8'h2D, 32'hFFFFFFFD};
    vecs[2] = '{32'h10000,      32'h10000,      8'h2A, 32'd0};
    vecs[3] = '{32'hFFFFFFFF,   32'd1,          8'h2B, 32'd0};
    vecs[4] = '{32'd7,          32'd6,          8'h2A, 32'd42};
    vecs[5] = '{32'd0,          32'd1,          8'h2D, 32'hFFFFFFFF};
    vecs[6] = '{32'h12345678,   32'h11111111,   8'h2B, 32'h23456789};
    vecs[7] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   8'h2A, 32'd1};

    rst = 1'b1; tok_stb = 1'b0; tok_is_op = 1'b0; tok_dat = 32'd0;
    push_ack = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_res_vld", {31'd0, res_vld}, 32'd0);
    check("rst_res_dat", res_dat, 32'd0);
    check("rst_push_dat", push_dat, 32'd0);
    check("rst_push_stb", {31'd0, push_stb}, 32'd0);
    check("rst_pop_ack", {31'd0, pop_ack}, 32'd0);
    check("rst_tok_ack", {31'd0, tok_ack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // arithmetic table, including latency of both token kinds
    for (int k = 0; k < 8; k++) begin
      push_val(vecs[k].a, 1'b1);
      check("operand_latency", 32'(push_done_cyc - ack_cyc), 32'd2);
      check("single_res_vld", {31'd0, res_vld}, 32'd1);
      push_val(vecs[k].b, 1'b1);
      check("two_res_vld", {31'd0, res_vld}, 32'd0);
      exp_q.push_back(vecs[k].r);
      p0 = pop_cnt;
      send_op(vecs[k].op);
      check("operator_latency", 32'(push_done_cyc - ack_cyc), 32'd5);
      check("operator_pops", 32'(pop_cnt - p0), 32'd2);
      check("result_dat", res_dat, vecs[k].r);
      check("result_vld", {31'd0, res_vld}, 32'd1);
      check("result_err", {31'd0, err}, 32'd0);
      do_clear();
      check("clear_sp", 32'(sp), 32'd0);
    end

    // full stack: 17th operand errors, then clear drains 16 entries
    for (int i = 0; i < 16; i++) push_val(32'd100 + 32'(i), 1'b1);
    check("full_sp", 32'(sp), 32'd16);
    push_val(32'd999, 1'b0);
    check("overflow_err", {31'd0, err}, 32'd1);
    check("overflow_sp", 32'(sp), 32'd16);
    p0 = pop_cnt;
    do_clear();
    check("drain_pops", 32'(pop_cnt - p0), 32'd16);
    check("drain_err", {31'd0, err}, 32'd0);
    check("drain_res_vld", {31'd0, res_vld}, 32'd0);
    push_val(32'd5, 1'b1);
    check("after_drain_vld", {31'd0, res_vld}, 32'd1);
    check("after_drain_dat", res_dat, 32'd5);
    do_clear();

    // operator with one operand: error, no pop, further tokens blocked until clear
    push_val(32'd9, 1'b1);
    p0 = pop_cnt;
    send_op(8'h2B);
    check("underflow_err", {31'd0, err}, 32'd1);
    check("underflow_pops", 32'(pop_cnt - p0), 32'd0);
    check("underflow_vld", {31'd0, res_vld}, 32'd0);
    send_tok(1'b0, 32'd1, 5, acked);
    check("blocked_ack", {31'd0, acked}, 32'd0);
    do_clear();
    check("underflow_clear_err", {31'd0, err}, 32'd0);

    // unsupported operator code
    push_val(32'd6, 1'b1);
    push_val(32'd6, 1'b1);
    p0 = pop_cnt;
    send_op(8'h25);
    check("bad_op_err", {31'd0, err}, 32'd1);
    check("bad_op_pops", 32'(pop_cnt - p0), 32'd0);
    do_clear();

    // push ack withheld for three cycles of PUSH_R
    push_val(32'd10, 1'b1);
    push_val(32'd20, 1'b1);
    push_ack = 1'b0;
    exp_q.push_back(32'd30);
    send_tok(1'b1, {24'd0, 8'h2B}, 5, acked);
    for (int i = 0; i < 10 && !push_stb; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_stb", {31'd0, push_stb}, 32'd1);
      check("stall_dat", push_dat, 32'd30);
      @(negedge clk);
    end
    push_ack = 1'b1;
    #1;
    check("stall_stb_4th", {31'd0, push_stb}, 32'd1);
    @(negedge clk);
    check("stall_done_busy", {31'd0, busy}, 32'd0);
    check("stall_done_dat", res_dat, 32'd30);
    do_clear();

`ifdef RPN_CTRL_DIV_EN
    push_val(32'd7, 1'b1);
    push_val(32'hFFFFFFFE, 1'b1);
    exp_q.push_back(32'hFFFFFFFD);
    send_op(8'h2F);
    check("div_res", res_dat, 32'hFFFFFFFD);
    do_clear();
    push_val(32'd7, 1'b1);
    push_val(32'd0, 1'b1);
    p0 = pop_cnt;
    send_op(8'h2F);
    check("div0_err", {31'd0, err}, 32'd1);
    check("div0_pops", 32'(pop_cnt - p0), 32'd2);
    check("div0_sp", 32'(sp), 32'd0);
    do_clear();
`else
    push_val(32'd7, 1'b1);
    push_val(32'd0, 1'b1);
    p0 = pop_cnt;
    send_op(8'h2F);
    check("div_unsupported_err", {31'd0, err}, 32'd1);
    check("div_unsupported_pops", 32'(pop_cnt - p0), 32'd0);
    do_clear();
`endif

    // reset while in EXEC abandons the operation
    push_val(32'd3, 1'b1);
    push_val(32'd4, 1'b1);
    send_tok(1'b1, {24'd0, 8'h2B}, 5, acked);
    for (int i = 0; i < 10 && dbg_state != 3'd4; i++) @(negedge clk);
    check("reached_exec", {29'd0, dbg_state}, 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("exec_rst_busy", {31'd0, busy}, 32'd0);
    check("exec_rst_push_stb", {31'd0, push_stb}, 32'd0);
    check("exec_rst_push_dat", push_dat, 32'd0);
    check("exec_rst_pop_ack", {31'd0, pop_ack}, 32'd0);
    check("exec_rst_res_dat", res_dat, 32'd0);
    check("exec_rst_res_vld", {31'd0, res_vld}, 32'd0);
    check("exec_rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_push_stb", {31'd0, push_stb}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
